alu_seg_addsub: RTL and testbench
=================================

// Module: alu_seg_addsub
// PURPOSE
//   Parametrised multi-cycle integer ALU: add/sub, logic ops and compares on WIDTH-bit operands.
//   Adds a valid/ready handshake on input and output.
//   Processes one SLICE-bit chunk per cycle through a ripple carry held in a register,
//   so wide datapaths reuse one narrow adder.
//   Reports carry, signed overflow, zero and negative flags.
//   Sits between the operand-fetch stage and the writeback stage of the datapath.
// PARAMETERS
//   WIDTH  32  operand/result width in bits; must be a multiple of SLICE
//   SLICE   8  bits processed per cycle; NSLICE = WIDTH/SLICE (derived, >= 1)
// PORTS
//   clock            in   1      rising-edge clock
//   reset            in   1      asynchronous, active-low reset (0 = reset)
//   io_in_valid      in   1      operand bundle valid
//   io_in_ready      out  1      block can accept an operand bundle
//   io_in_a          in   WIDTH  operand A
//   io_in_b          in   WIDTH  operand B
//   io_in_op         in   3      0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 PASSB
//   io_out_valid     out  1      result bundle valid
//   io_out_ready     in   1      downstream accepts result
//   io_out_result    out  WIDTH  result
//   io_out_carry     out  1      carry-out (ADD); no-borrow, i.e. A >= B unsigned (SUB/SLT/SLTU)
//   io_out_overflow  out  1      signed overflow (ADD/SUB/SLT/SLTU)
//   io_out_zero      out  1      io_out_result == 0
//   io_out_negative  out  1      io_out_result[WIDTH-1]
// BEHAVIOUR
//   Reset state: FSM in IDLE, io_out_valid 0, result 0, all flags 0.
//     io_in_ready is 1 once reset is released.
//   FSM states: IDLE -> RUN -> DONE -> IDLE.
//     IDLE: io_in_ready = 1. On io_in_valid=1, latch A, B, op and go to RUN.
//       - slice index idx := 0
//       - carry := 1 for SUB/SLT/SLTU, else 0
//       - zero accumulator := 1
//     RUN: io_in_ready = 0. Each cycle compute slice idx.
//       - ADD-class ops: sum = A[idx] + B'[idx] + carry, where B' = ~B for SUB/SLT/SLTU, else B.
//       - The sum is written into result slice idx, and carry is updated.
//       - AND/OR/XOR/PASSB compute their slice bitwise; carry is not updated.
//       - zero_acc &= (slice == 0).
//       - When idx == NSLICE-1, go to DONE; idx saturates (no wrap).
//     DONE: io_out_valid = 1, outputs stable.
//       - On io_out_valid & io_out_ready, go to IDLE. io_out_valid drops the next cycle.
//       - No new operand is accepted in DONE: io_in_ready = 0 and io_in_valid is ignored.
//   Latency: io_out_valid rises exactly NSLICE cycles after the accepting edge.
//     Latency is identical for all ops.
//   Throughput: at most one operation per NSLICE+2 cycles (one-cycle IDLE gap).
//   Flags, latched on the final slice edge:
//     - ADD/SUB: carry = final carry; overflow = (A[MSB]==B'[MSB]) & (sum[MSB]!=A[MSB]).
//     - SLT: result = {0, N^V}; SLTU: result = {0, ~carry}.
//       For both, carry/overflow reflect the internal A-B.
//     - AND/OR/XOR/PASSB: carry = 0, overflow = 0.
//     - zero and negative always describe io_out_result itself,
//       including SLT/SLTU, where zero is recomputed on the final result.
//   Boundaries:
//     - NSLICE == 1 gives single-cycle RUN.
//     - Undefined op encodings do not exist (all 8 defined).
//     - io_in_* may change freely outside IDLE; only the accept-cycle values matter.
//   Reset mid-RUN or mid-DONE: operation abandoned; all state returns to reset values.
//     No partial result is emitted.
// TESTING (WIDTH=32, SLICE=8 unless stated)
//   1. ADD A=0xFFFF_FFFF B=0x0000_0001
//      -> result 0, carry 1, zero 1, overflow 0, negative 0; io_out_valid exactly 4 cycles after accept.
//   2. SUB A=0x8000_0000 B=0x1
//      -> result 0x7FFF_FFFF, overflow 1, carry 1, negative 0, zero 0.
//   3. SLT A=0xFFFF_FFFF B=0x1 -> result 1. SLTU with the same operands -> result 0, zero 1.
//   4. Hold io_out_ready=0 for 10 cycles after valid, toggling io_in_valid
//      -> outputs stable, io_in_ready 0, nothing accepted; ready=1 -> IDLE next cycle.
//   5. Assert reset after 2 slices of an ADD
//      -> io_out_valid 0, result/flags 0, io_in_ready 1; next XOR 0xF0F0_F0F0^0xFFFF_FFFF = 0x0F0F_0F0F.
//   6. WIDTH=SLICE=8: ADD 0x7F+0x01 -> 0x80, overflow 1, negative 1, latency 1 cycle.

Source files
------------

// File: rtl/alu_seg_addsub.sv
// Multi-cycle integer ALU that walks WIDTH-bit operands one SLICE-bit chunk per cycle,
// carrying the ripple carry in a register, with valid/ready handshakes on both sides.
module alu_seg_addsub #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_a,
    input  logic [WIDTH-1:0] io_in_b,
    input  logic [2:0]       io_in_op,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_result,
    output logic             io_out_carry,
    output logic             io_out_overflow,
    output logic             io_out_zero,
    output logic             io_out_negative
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_SLT   = 3'd5;
    localparam logic [2:0] OP_SLTU  = 3'd6;
    localparam logic [2:0] OP_PASSB = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [2:0]       op_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q, zero_acc_q;

    logic [WIDTH-1:0] result_q;
    logic             flag_c_q, flag_v_q, flag_z_q, flag_n_q;

    // SUB and both compares run A + ~B + 1 through the adder.
    function automatic logic is_sub_op(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
    endfunction

    logic [SLICE-1:0] a_s, b_s, bx_s, slice_res;
    logic [SLICE:0]   sum_s;
    logic [WIDTH-1:0] res_full, fin_res;
    logic             last, ovf, cout, zero_slice, lt_bit;
    logic             fin_c, fin_v, fin_z;
    int               base;

    assign io_in_ready     = (state_q == S_IDLE);
    assign io_out_valid    = (state_q == S_DONE);
    assign io_out_result   = result_q;
    assign io_out_carry    = flag_c_q;
    assign io_out_overflow = flag_v_q;
    assign io_out_zero     = flag_z_q;
    assign io_out_negative = flag_n_q;

    always_comb begin
        base       = int'(idx_q) * SLICE;
        a_s        = a_q[base +: SLICE];
        b_s        = b_q[base +: SLICE];
        bx_s       = is_sub_op(op_q) ? ~b_s : b_s;
        sum_s      = {1'b0, a_s} + {1'b0, bx_s} + {{SLICE{1'b0}}, carry_q};
        cout       = sum_s[SLICE];
        ovf        = (a_s[SLICE-1] == bx_s[SLICE-1]) && (sum_s[SLICE-1] != a_s[SLICE-1]);
        last       = (idx_q == LAST_IDX);

        case (op_q)
            OP_AND:   slice_res = a_s & b_s;
            OP_OR:    slice_res = a_s | b_s;
            OP_XOR:   slice_res = a_s ^ b_s;
            OP_PASSB: slice_res = b_s;
            default:  slice_res = sum_s[SLICE-1:0];
        endcase

        zero_slice = zero_acc_q && (slice_res == '0);
        res_full   = res_q;
        res_full[base +: SLICE] = slice_res;

        // Final-slice view: compares collapse the difference to a single bit.
        lt_bit  = (op_q == OP_SLT) ? (sum_s[SLICE-1] ^ ovf) : ~cout;
        fin_res = res_full;
        fin_c   = 1'b0;
        fin_v   = 1'b0;
        fin_z   = zero_slice;
        case (op_q)
            OP_ADD, OP_SUB: begin
                fin_c = cout;
                fin_v = ovf;
            end
            OP_SLT, OP_SLTU: begin
                fin_res    = '0;
                fin_res[0] = lt_bit;
                fin_c      = cout;
                fin_v      = ovf;
                fin_z      = ~lt_bit;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (io_in_valid) state_d = S_RUN;
            S_RUN:  if (last) state_d = S_DONE;
            S_DONE: if (io_out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_ADD;
            res_q      <= '0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            zero_acc_q <= 1'b0;
            result_q   <= '0;
            flag_c_q   <= 1'b0;
            flag_v_q   <= 1'b0;
            flag_z_q   <= 1'b0;
            flag_n_q   <= 1'b0;
        end else begin
            if (state_q == S_IDLE && io_in_valid) begin
                a_q        <= io_in_a;
                b_q        <= io_in_b;
                op_q       <= io_in_op;
                idx_q      <= '0;
                carry_q    <= is_sub_op(io_in_op);
                zero_acc_q <= 1'b1;
            end
            if (state_q == S_RUN) begin
                res_q      <= res_full;
                zero_acc_q <= zero_slice;
                if (!(op_q inside {OP_AND, OP_OR, OP_XOR, OP_PASSB})) carry_q <= cout;
                if (!last) idx_q <= idx_q + 1'b1;
                if (last) begin
                    result_q <= fin_res;
                    flag_c_q <= fin_c;
                    flag_v_q <= fin_v;
                    flag_z_q <= fin_z;
                    flag_n_q <= fin_res[WIDTH-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seg_addsub.sv
// Scoreboard bench for alu_seg_addsub: a 32/8 instance for the main vectors and an
// 8/8 instance for the single-slice case.
module tb_alu_seg_addsub;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // 32-bit, 4-slice instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_result;
    logic [2:0]  in_op;
    logic        out_carry, out_overflow, out_zero, out_negative;

    // 8-bit, 1-slice instance
    logic        in8_valid, in8_ready, out8_valid, out8_ready;
    logic [7:0]  in8_a, in8_b, out8_result;
    logic [2:0]  in8_op;
    logic        out8_carry, out8_overflow, out8_zero, out8_negative;

    alu_seg_addsub #(.WIDTH(32), .SLICE(8)) dut (
        .clock(clock), .reset(reset),
        .io_in_valid(in_valid), .io_in_ready(in_ready),
        .io_in_a(in_a), .io_in_b(in_b), .io_in_op(in_op),
        .io_out_valid(out_valid), .io_out_ready(out_ready),
        .io_out_result(out_result), .io_out_carry(out_carry),
        .io_out_overflow(out_overflow), .io_out_zero(out_zero),
        .io_out_negative(out_negative)
    );

    alu_seg_addsub #(.WIDTH(8), .SLICE(8)) dut8 (
        .clock(clock), .reset(reset),
        .io_in_valid(in8_valid), .io_in_ready(in8_ready),
        .io_in_a(in8_a), .io_in_b(in8_b), .io_in_op(in8_op),
        .io_out_valid(out8_valid), .io_out_ready(out8_ready),
        .io_out_result(out8_result), .io_out_carry(out8_carry),
        .io_out_overflow(out8_overflow), .io_out_zero(out8_zero),
        .io_out_negative(out8_negative)
    );

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        c, v, z, n;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp8_q[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitors: compare whenever a result is handed downstream.
    always @(negedge clock) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got result 0x%08h, expected no output", out_result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.tag, "_result"},   out_result,   e.res);
                check({e.tag, "_carry"},    out_carry,    e.c);
                check({e.tag, "_overflow"}, out_overflow, e.v);
                check({e.tag, "_zero"},     out_zero,     e.z);
                check({e.tag, "_negative"}, out_negative, e.n);
            end
        end
    end

    always @(negedge clock) begin
        if (out8_valid && out8_ready) begin
            if (exp8_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output8: got result 0x%02h, expected no output", out8_result);
            end else begin
                exp_t e;
                e = exp8_q.pop_front();
                check({e.tag, "_result"},   {24'd0, out8_result}, e.res);
                check({e.tag, "_carry"},    out8_carry,    e.c);
                check({e.tag, "_overflow"}, out8_overflow, e.v);
                check({e.tag, "_zero"},     out8_zero,     e.z);
                check({e.tag, "_negative"}, out8_negative, e.n);
            end
        end
    end

    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r, input logic c,
                         input logic v, input logic z, input logic n, input bit hold);
        int lat;
        int guard;
        exp_t e;
        @(negedge clock);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        check({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_op = op;
        e.tag = tag; e.res = r; e.c = c; e.v = v; e.z = z; e.n = n;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_a = $urandom;
        in_b = $urandom;
        in_op = 3'($urandom_range(0, 7));
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 4);
        if (!hold) begin
            guard = 0;
            while (out_valid && guard < 50) begin
                @(posedge clock);
                #1;
                guard++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        exp_t e;
        reset = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
        in8_valid = 1'b0; in8_a = '0; in8_b = '0; in8_op = '0; out8_ready = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", out_result, 0);
        check("rst_flags", {out_carry, out_overflow, out_zero, out_negative}, 0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Directed vectors: tag, op, A, B, result, carry, overflow, zero, negative
        do_op("add_wrap",  3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 1, 0, 0);
        do_op("sub_ovf",   3'd1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1, 1, 0, 0, 0);
        do_op("slt_neg",   3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1, 0, 0, 0, 0);
        do_op("sltu_big",  3'd6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 1, 0, 0);
        do_op("add_ovf",   3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 1, 0, 1, 0);
        do_op("sub_borrow",3'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 0, 0, 0, 1, 0);
        do_op("sub_eq",    3'd1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1, 0, 1, 0, 0);
        do_op("and",       3'd2, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 0, 0, 0, 0, 0);
        do_op("passb",     3'd7, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 1, 0);
        do_op("sltu_lt",   3'd6, 32'h0000_0001, 32'h0000_0002, 32'h0000_0001, 0, 0, 0, 0, 0);
        do_op("slt_vflip", 3'd5, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1, 1, 0, 0, 0);

        // Back-pressure: outputs hold, input ignored while result is pending
        out_ready = 1'b0;
        do_op("or_hold", 3'd3, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("hold_valid", out_valid, 1);
            check("hold_result", out_result, 32'h1234_5678);
            check("hold_in_ready", in_ready, 0);
            in_valid = ~in_valid;
            in_a = $urandom;
            in_op = 3'd0;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("release_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        repeat (6) @(posedge clock);
        #1;
        check("nothing_accepted", out_valid, 0);

        // Reset in the middle of an ADD
        @(negedge clock);
        in_valid = 1'b1; in_a = 32'h0000_00FF; in_b = 32'h0000_0001; in_op = 3'd0;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_result", out_result, 0);
        check("midrst_flags", {out_carry, out_overflow, out_zero, out_negative}, 0);
        check("midrst_in_ready", in_ready, 1);
        @(negedge clock);
        reset = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        check("midrst_no_output", out_valid, 0);
        do_op("xor_after", 3'd4, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 0, 0, 0, 0, 0);

        // Single-slice instance
        @(negedge clock);
        in8_valid = 1'b1; in8_a = 8'h7F; in8_b = 8'h01; in8_op = 3'd0;
        e.tag = "w8_add"; e.res = 32'h80; e.c = 0; e.v = 1; e.z = 0; e.n = 1;
        exp8_q.push_back(e);
        @(posedge clock);
        #1;
        in8_valid = 1'b0;
        lat = 0;
        while (!out8_valid && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check("w8_add_latency", lat, 1);
        @(posedge clock);
        #1;
        @(negedge clock);
        in8_valid = 1'b1; in8_a = 8'h00; in8_b = 8'h01; in8_op = 3'd1;
        e.tag = "w8_sub"; e.res = 32'hFF; e.c = 0; e.v = 0; e.z = 0; e.n = 1;
        exp8_q.push_back(e);
        @(posedge clock);
        #1;
        in8_valid = 1'b0;
        lat = 0;
        while (!out8_valid && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check("w8_sub_latency", lat, 1);

        repeat (5) @(posedge clock);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        check("scoreboard8_drained", exp8_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
